// File: rtl/serial_arbiter.sv
// Round-robin arbiter that grants one requester at a time and serialises its word MSB-first.
// Optional build macro SER_PARITY_EN appends one even-parity bit to every frame.
module serial_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      din,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] src,
    output logic                    data,
    output logic                    frame,
    output logic [DW-1:0]           o,
    output logic                    done
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   src_q, src_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic [DW-1:0]   word_q, word_d;
    logic [DW-1:0]   o_q, o_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            frame_q, frame_d;
    logic            data_q, data_d;
    logic            done_q, done_d;

    logic [DW-1:0]   words [NREQ];
    logic            found;
    logic [SW-1:0]   win;
    logic            finish;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            words[k] = din[k*DW +: DW];
        end
    end

    // Search starts just after the last winner, so every requester is reached within NREQ grants.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[SW'((int'(ptr_q) + i) % NREQ)]) begin
                found = 1'b1;
                win   = SW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        sh_d    = sh_q;
        word_d  = word_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        data_d  = data_q;
        done_d  = 1'b0;
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_SHIFT;
                    ptr_d      = win;
                    src_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    ack_d      = '0;
                    ack_d[win] = 1'b1;
                    sh_d       = words[win];
                    word_d     = words[win];
                    cnt_d      = CW'(DW - 1);
                    frame_d    = 1'b1;
                    data_d     = words[win][DW-1];
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
`ifdef SER_PARITY_EN
                    state_d = S_PARITY;
                    data_d  = ^word_q;
`else
                    finish  = 1'b1;
`endif
                end else begin
                    sh_d   = sh_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                    data_d = sh_d[DW-1];
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: finish = 1'b1;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Frame end: the captured word is published and the grant released; src keeps its value.
        if (finish) begin
            state_d = S_DONE;
            frame_d = 1'b0;
            data_d  = 1'b0;
            gnt_d   = '0;
            o_d     = word_q;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= SW'(NREQ - 1);
            src_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            o_q     <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign src   = src_q;
    assign data  = data_q;
    assign frame = frame_q;
    assign o     = o_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_arbiter.sv
// Scoreboard bench for serial_arbiter: a transaction-level model predicts grants and frames,
// and an independent monitor compares them against what the DUT presents.
module tb_serial_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 4;
`ifdef SER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*DW-1:0]      din = '0;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         ack;
    logic [$clog2(NREQ)-1:0] src;
    logic                    data;
    logic                    frame;
    logic [DW-1:0]           o;
    logic                    done;

    serial_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .ack   (ack),
        .src   (src),
        .data  (data),
        .frame (frame),
        .o     (o),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            src;
        logic [DW-1:0] word;
        int            e_cyc;
    } txn_t;

    txn_t gq[$];
    txn_t dq[$];
    int   cyc    = 0;
    int   m_ptr  = NREQ - 1;
    int   m_free = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: round-robin choice from the request vector, fixed frame timing.
    initial forever begin
        int   w;
        txn_t t;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ptr  = NREQ - 1;
            m_free = 0;
            gq.delete();
            dq.delete();
        end else begin
            cyc++;
            if (cyc >= m_free && req != '0) begin
                w = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
                end
                t.src   = w;
                t.word  = din[w*DW +: DW];
                t.e_cyc = cyc;
                gq.push_back(t);
                t.e_cyc = cyc + FL;
                dq.push_back(t);
                m_ptr  = w;
                m_free = cyc + FL + 2;
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations when ack/done appear.
    initial forever begin
        txn_t        t;
        int          cur;
        int          nbits;
        logic [DW:0] got;
        logic [DW:0] exp_bits;
        @(negedge clk);
        if (!rst_n) begin
            nbits = 0;
            got   = '0;
        end else begin
            if (ack != '0) begin
                if (gq.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'(0));
                end else begin
                    t = gq.pop_front();
                    check("ack_cycle", 64'(cyc), 64'(t.e_cyc));
                    check("ack_onehot", 64'(ack), 64'(1) << t.src);
                    check("gnt_at_grant", 64'(gnt), 64'(1) << t.src);
                    check("src_at_grant", 64'(src), 64'(t.src));
                    cur = t.src;
                end
            end
            if (frame) begin
                got = {got[DW-1:0], data};
                nbits++;
                check("gnt_held", 64'(gnt), 64'(1) << cur);
            end else begin
                check("data_idle", 64'(data), 64'(0));
            end
            if (done) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'(0));
                end else begin
                    t = dq.pop_front();
`ifdef SER_PARITY_EN
                    exp_bits = {t.word, ^t.word};
`else
                    exp_bits = {1'b0, t.word};
`endif
                    check("done_cycle", 64'(cyc), 64'(t.e_cyc));
                    check("o_word", 64'(o), 64'(t.word));
                    check("frame_len", 64'(nbits), 64'(FL));
                    check("frame_bits", 64'(got), 64'(exp_bits));
                    check("src_hold", 64'(src), 64'(t.src));
                    check("gnt_released", 64'(gnt), 64'(0));
                end
                nbits = 0;
                got   = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] w);
        din[k*DW +: DW] = w;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'(0));
        check({tag, "_ack"}, 64'(ack), 64'(0));
        check({tag, "_src"}, 64'(src), 64'(0));
        check({tag, "_data"}, 64'(data), 64'(0));
        check({tag, "_frame"}, 64'(frame), 64'(0));
        check({tag, "_o"}, 64'(o), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Single request from source 2.
        set_word(2, 4'b1011);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(FL + 4);

        // All sources requesting continuously.
        req = 4'b1111;
        for (int c = 0; c < 6 * (FL + 2); c++) begin
            din = (NREQ*DW)'($urandom);
            tick(1);
        end
        req = '0;
        tick(FL + 4);

        // Request and word change during the transfer.
        set_word(1, 4'b0110);
        req = 4'b0010;
        tick(1);
        req = '0;
        set_word(1, 4'b1111);
        tick(FL + 4);

        // Request arriving during the DONE cycle.
        set_word(0, 4'b1100);
        set_word(3, 4'b0011);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(FL);
        req = 4'b1000;
        tick(3);
        req = '0;
        tick(FL + 4);

        // Reset in the middle of a frame.
        set_word(0, 4'b0101);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        tick(2);
        rst_n = 1'b1;
        set_word(0, 4'b1010);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(FL + 4);

        // Randomised requests and words.
        for (int c = 0; c < 400; c++) begin
            din = (NREQ*DW)'($urandom);
            req = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            tick(1);
        end
        req = '0;
        tick(2 * (FL + 4));

        check("grants_drained", 64'(gq.size()), 64'(0));
        check("frames_drained", 64'(dq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
